sys1_sound_mailbox: RTL and testbench

- Parametrised successor to the single-byte sound-request latch in the System 1 main board.
- Decodes main-CPU I/O writes to the command ports and queues command bytes in a FIFO of depth 2^DEPTH_LOG2.
- Holds a sound-CPU request line (level or timed pulse) while commands are pending and exposes a status register the main CPU can read back.
- Runs entirely in the 48 MHz domain; the CPU side supplies single-cycle strobes.

---
 rtl/sys1_sound_mailbox.sv | 130 +++++++++++++
 tb/tb_sys1_sound_mailbox.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys1_sound_mailbox.sv
// rtl/sys1_sound_mailbox.sv - main-CPU to sound-CPU command FIFO with request line and status register
// Single-clock mailbox: decoded I/O writes queue bytes, the sound CPU pops them, SNDRQ flags pending work.
module sys1_sound_mailbox #(
   parameter int unsigned DEPTH_LOG2   = 2,
   parameter logic [7:0]  CMD_ADDR_A   = 8'h14,
   parameter logic [7:0]  CMD_ADDR_B   = 8'h18,
   parameter logic [7:0]  STAT_ADDR    = 8'h16,
   parameter bit          RQ_PULSE     = 1'b0,
   parameter int unsigned PULSE_LEN    = 16,
   parameter bit          OVF_DROP_NEW = 1'b1
) (
   input  logic       CLK48M,
   input  logic       RESETn,
   input  logic [7:0] CPUAD,
   input  logic [7:0] CPUDO,
   input  logic       IOWR_STB,
   input  logic       IORD,
   input  logic       IORD_STB,
   output logic       STAT_CS,
   output logic [7:0] STAT_DO,
   input  logic       SND_POP,
   output logic [7:0] SND_DO,
   output logic       SNDRQ
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   typedef enum logic {ST_IDLE, ST_ACTIVE} rq_state_e;

   logic [7:0]            mem_q [DEPTH];
   logic [7:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            timer_q, timer_d;
   rq_state_e             state_q, state_d;
   logic                  sndrq_q, sndrq_d;

   logic push_req, pop_ok, ovf_set, wr_en, rd_adv, trigger, empty, full;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign STAT_CS = IORD & (CPUAD == STAT_ADDR);
   assign STAT_DO = {ovf_q, full, empty, 5'(count_q)};
   assign SND_DO  = empty ? 8'h00 : mem_q[rptr_q];
   assign SNDRQ   = sndrq_q;

   always_comb begin
      push_req = IOWR_STB & ((CPUAD == CMD_ADDR_A) | (CPUAD == CMD_ADDR_B));
      pop_ok   = SND_POP & ~empty;
      // A simultaneous pop frees the slot, so a push into a full FIFO is then not an overflow.
      ovf_set  = push_req & full & ~pop_ok;
      wr_en    = push_req & (~full | pop_ok | ~OVF_DROP_NEW);
      rd_adv   = pop_ok | (ovf_set & ~OVF_DROP_NEW);

      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wptr_q] = CPUDO;
      end
      wptr_d  = wptr_q + DEPTH_LOG2'(wr_en);
      rptr_d  = rptr_q + DEPTH_LOG2'(rd_adv);
      count_d = count_q + CW'(wr_en) - CW'(rd_adv);

      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (IORD_STB & STAT_CS) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      trigger = (wr_en & empty) | (pop_ok & (count_d != '0));
      state_d = state_q;
      timer_d = timer_q;
      if (RQ_PULSE) begin
         case (state_q)
            ST_IDLE: begin
               if (trigger) begin
                  state_d = ST_ACTIVE;
                  timer_d = 8'(PULSE_LEN);
               end
            end
            ST_ACTIVE: begin
               if (trigger) begin
                  timer_d = 8'(PULSE_LEN);
               end else if (timer_q == 8'd1) begin
                  state_d = ST_IDLE;
                  timer_d = 8'd0;
               end else begin
                  timer_d = timer_q - 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = 8'd0;
            end
         endcase
         sndrq_d = (state_d == ST_ACTIVE);
      end else begin
         sndrq_d = ~empty;
      end
   end

   always_ff @(posedge CLK48M or negedge RESETn) begin
      if (!RESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         timer_q <= 8'd0;
         state_q <= ST_IDLE;
         sndrq_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         timer_q <= timer_d;
         state_q <= state_d;
         sndrq_q <= sndrq_d;
      end
   end

endmodule

// File: tb/tb_sys1_sound_mailbox.sv
// tb/tb_sys1_sound_mailbox.sv - bench for sys1_sound_mailbox against a queue-level reference model
// Three variants share one stimulus stream: drop-new level, overwrite level, drop-new pulse.
module tb_sys1_sound_mailbox;

   localparam int NI = 3;
   localparam int DEPTH_TAB [NI] = '{4, 4, 4};
   localparam bit DROP_TAB  [NI] = '{1'b1, 1'b0, 1'b1};
   localparam bit PULSE_TAB [NI] = '{1'b0, 1'b0, 1'b1};
   localparam int PLEN = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] cpuad = 8'h00;
   logic [7:0] cpudo = 8'h00;
   logic iowr_stb = 1'b0;
   logic iord = 1'b0;
   logic iord_stb = 1'b0;
   logic snd_pop = 1'b0;

   logic [NI-1:0]      stat_cs_w, sndrq_w;
   logic [NI-1:0][7:0] stat_do_w, snd_do_w;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   logic [7:0] mbuf [NI][16];
   int msize [NI];
   bit movf [NI];
   bit mlvl [NI];
   int mrem [NI];

   always #5 clk = ~clk;

   sys1_sound_mailbox #(.DEPTH_LOG2(2), .RQ_PULSE(1'b0), .OVF_DROP_NEW(1'b1)) u0 (
      .CLK48M(clk), .RESETn(rst_n), .CPUAD(cpuad), .CPUDO(cpudo), .IOWR_STB(iowr_stb),
      .IORD(iord), .IORD_STB(iord_stb), .STAT_CS(stat_cs_w[0]), .STAT_DO(stat_do_w[0]),
      .SND_POP(snd_pop), .SND_DO(snd_do_w[0]), .SNDRQ(sndrq_w[0]));

   sys1_sound_mailbox #(.DEPTH_LOG2(2), .RQ_PULSE(1'b0), .OVF_DROP_NEW(1'b0)) u1 (
      .CLK48M(clk), .RESETn(rst_n), .CPUAD(cpuad), .CPUDO(cpudo), .IOWR_STB(iowr_stb),
      .IORD(iord), .IORD_STB(iord_stb), .STAT_CS(stat_cs_w[1]), .STAT_DO(stat_do_w[1]),
      .SND_POP(snd_pop), .SND_DO(snd_do_w[1]), .SNDRQ(sndrq_w[1]));

   sys1_sound_mailbox #(.DEPTH_LOG2(2), .RQ_PULSE(1'b1), .PULSE_LEN(PLEN), .OVF_DROP_NEW(1'b1)) u2 (
      .CLK48M(clk), .RESETn(rst_n), .CPUAD(cpuad), .CPUDO(cpudo), .IOWR_STB(iowr_stb),
      .IORD(iord), .IORD_STB(iord_stb), .STAT_CS(stat_cs_w[2]), .STAT_DO(stat_do_w[2]),
      .SND_POP(snd_pop), .SND_DO(snd_do_w[2]), .SNDRQ(sndrq_w[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_do(input int i);
      return (msize[i] == 0) ? 8'h00 : mbuf[i][0];
   endfunction

   function automatic logic [7:0] exp_stat(input int i);
      return {movf[i], msize[i] == DEPTH_TAB[i], msize[i] == 0, 5'(msize[i])};
   endfunction

   function automatic logic exp_rq(input int i);
      return PULSE_TAB[i] ? (mrem[i] > 0) : mlvl[i];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         msize[i] = 0;
         movf[i] = 1'b0;
         mlvl[i] = 1'b0;
         mrem[i] = 0;
      end
   endtask

   task automatic q_pop(input int i);
      for (int k = 0; k < 15; k++) mbuf[i][k] = mbuf[i][k+1];
      msize[i]--;
   endtask

   task automatic q_push(input int i, input logic [7:0] d);
      mbuf[i][msize[i]] = d;
      msize[i]++;
   endtask

   // Queue-level view of one clock edge, using the inputs presented before it.
   task automatic model_step();
      bit push, pop, trig, oset, cs;
      push = iowr_stb && (cpuad == 8'h14 || cpuad == 8'h18);
      cs = iord && (cpuad == 8'h16);
      for (int i = 0; i < NI; i++) begin
         pop = snd_pop && (msize[i] > 0);
         trig = 1'b0;
         oset = 1'b0;
         mlvl[i] = (msize[i] != 0);
         if (push && pop) begin
            q_pop(i);
            q_push(i, cpudo);
            trig = 1'b1;
         end else if (pop) begin
            q_pop(i);
            trig = (msize[i] >= 1);
         end else if (push) begin
            if (msize[i] < DEPTH_TAB[i]) begin
               trig = (msize[i] == 0);
               q_push(i, cpudo);
            end else begin
               oset = 1'b1;
               if (!DROP_TAB[i]) begin
                  q_pop(i);
                  q_push(i, cpudo);
               end
            end
         end
         if (oset) movf[i] = 1'b1;
         else if (iord_stb && cs) movf[i] = 1'b0;
         if (trig) mrem[i] = PLEN;
         else if (mrem[i] > 0) mrem[i]--;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d snd_do", i), snd_do_w[i], exp_do(i));
            chk($sformatf("u%0d stat_do", i), stat_do_w[i], exp_stat(i));
            chk($sformatf("u%0d sndrq", i), sndrq_w[i], exp_rq(i));
            chk($sformatf("u%0d stat_cs", i), stat_cs_w[i], iord && (cpuad == 8'h16));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      iowr_stb = 1'b0;
      snd_pop = 1'b0;
      iord_stb = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      cpuad = a;
      cpudo = d;
      iowr_stb = 1'b1;
      tick();
   endtask

   task automatic pop_t();
      snd_pop = 1'b1;
      tick();
   endtask

   task automatic stat_read();
      cpuad = 8'h16;
      iord = 1'b1;
      iord_stb = 1'b1;
      tick();
      iord = 1'b0;
   endtask

   initial begin
      int n;
      logic [7:0] exp0, exp1;
      model_reset();
      #12;
      chk("reset stat_do", stat_do_w[0], 8'h20);
      chk("reset snd_do", snd_do_w[0], 8'h00);
      chk("reset sndrq", sndrq_w[2], 1'b0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      wr(8'h14, 8'h3A);
      chk("first snd_do", snd_do_w[0], 8'h3A);
      chk("first stat_do", stat_do_w[0], 8'h01);
      chk("first sndrq early", sndrq_w[0], 1'b0);
      tick();
      chk("first sndrq", sndrq_w[0], 1'b1);

      do_reset();
      for (int k = 1; k <= 5; k++) wr(8'h18, 8'(k));
      chk("ovf drop stat", stat_do_w[0], 8'hC4);
      chk("ovf ovw stat", stat_do_w[1], 8'hC4);
      for (int k = 1; k <= 4; k++) begin
         exp0 = 8'(k);
         exp1 = 8'(k + 1);
         chk("drop pop seq", snd_do_w[0], exp0);
         chk("ovw pop seq", snd_do_w[1], exp1);
         pop_t();
      end
      chk("ovw ovf sticky", stat_do_w[1], 8'hA0);
      stat_read();
      chk("drop ovf clr", stat_do_w[0], 8'h20);
      chk("ovw ovf clr", stat_do_w[1], 8'h20);

      do_reset();
      wr(8'h14, 8'h10);
      n = int'(sndrq_w[2]);
      for (int s = 2; s <= 40; s++) begin
         tick();
         n += int'(sndrq_w[2]);
      end
      chk("pulse len", n, 16);

      do_reset();
      wr(8'h14, 8'h10);
      n = int'(sndrq_w[2]);
      for (int s = 2; s <= 60; s++) begin
         if (s == 2) snd_pop = 1'b1;
         if (s == 10) begin
            cpuad = 8'h14;
            cpudo = 8'h20;
            iowr_stb = 1'b1;
         end
         tick();
         n += int'(sndrq_w[2]);
      end
      chk("pulse stretch", n, 25);
      wr(8'h14, 8'h30);
      pop_t();
      n = int'(sndrq_w[2]);
      for (int s = 2; s <= 30; s++) begin
         tick();
         n += int'(sndrq_w[2]);
      end
      chk("pulse on pop", n, 16);
      chk("pulse head", snd_do_w[2], 8'h30);

      do_reset();
      for (int k = 1; k <= 4; k++) wr(8'h14, 8'hA0 + 8'(k));
      snd_pop = 1'b1;
      wr(8'h14, 8'hB5);
      chk("full pushpop stat", stat_do_w[0], 8'h44);
      chk("full pushpop head", snd_do_w[0], 8'hA2);
      for (int k = 0; k < 3; k++) pop_t();
      chk("full pushpop tail", snd_do_w[0], 8'hB5);

      do_reset();
      for (int k = 0; k < 3; k++) wr(8'h18, 8'h50 + 8'(k));
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async rst sndrq", sndrq_w[0], 1'b0);
      chk("async rst snd_do", snd_do_w[0], 8'h00);
      chk("async rst stat", stat_do_w[0], 8'h20);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wr(8'h15, 8'h77);
      wr(8'h19, 8'h78);
      chk("other addr", stat_do_w[0], 8'h20);

      for (int c = 0; c < 3000; c++) begin
         case ($urandom % 6)
            0: cpuad = 8'h14;
            1: cpuad = 8'h18;
            2: cpuad = 8'h16;
            3: cpuad = 8'h15;
            4: cpuad = 8'h19;
            default: cpuad = 8'($urandom);
         endcase
         cpudo = 8'($urandom);
         if (c < 1500) begin
            iowr_stb = ($urandom % 2) == 0;
            snd_pop = ($urandom % 5) == 0;
         end else begin
            iowr_stb = ($urandom % 5) == 0;
            snd_pop = ($urandom % 2) == 0;
         end
         iord = ($urandom % 3) == 0;
         iord_stb = iord && (($urandom % 2) == 0);
         if (($urandom % 400) == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end
      iord = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
